// File: rtl/pll_lock_supervisor.sv
// Per-channel PLL lock supervisor: sequences PLL reset, waits for a synchronised lock,
// qualifies it for STABLE_CYC cycles, retries on timeout and counts lock losses.

module pll_lock_ch #(
    parameter int STABLE_CYC    = 1024,
    parameter int TIMEOUT_CYC   = 65536,
    parameter int RST_PULSE_CYC = 16,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lock_in,
    input  logic             enable,
    input  logic             clr_err,
    output logic             pll_rst,
    output logic             stable,
    output logic             lost_pulse,
    output logic             fail,
    output logic [CNT_W-1:0] lost_cnt
);
    localparam int M1   = (STABLE_CYC > TIMEOUT_CYC) ? STABLE_CYC : TIMEOUT_CYC;
    localparam int MAXV = (M1 > RST_PULSE_CYC) ? M1 : RST_PULSE_CYC;
    localparam int TW   = $clog2(MAXV + 1);
    localparam int RW   = $clog2(MAX_RETRY + 1);

    localparam logic [TW-1:0] RST_LAST = TW'(RST_PULSE_CYC - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] ST_LAST  = TW'(STABLE_CYC - 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_DISABLED, S_RESET, S_WAIT, S_SETTLE, S_LOCKED, S_FAIL
    } state_e;

    state_e           state_q, state_d;
    logic [TW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    retry_q, retry_d, retry_inc;
    logic [CNT_W-1:0] lost_q, lost_d;
    logic             sync1_q, sync2_q;
    logic             rst_q, rst_d, stable_q, stable_d, pulse_q, pulse_d, fail_q, fail_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            state_q  <= S_DISABLED;
            cnt_q    <= '0;
            retry_q  <= '0;
            lost_q   <= '0;
            rst_q    <= 1'b1;
            stable_q <= 1'b0;
            pulse_q  <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            sync1_q  <= lock_in;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
            lost_q   <= lost_d;
            rst_q    <= rst_d;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
            fail_q   <= fail_d;
        end
    end

    // One counter serves the reset pulse, the lock timeout and the settle window.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        lost_d    = lost_q;
        pulse_d   = 1'b0;
        retry_inc = retry_q + 1'b1;
        if (!enable) begin
            state_d = S_DISABLED;
        end else begin
            case (state_q)
                S_DISABLED: begin
                    state_d = S_RESET;
                    cnt_d   = '0;
                    retry_d = '0;
                end
                S_RESET: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (sync2_q) begin
                        state_d = S_SETTLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TO_LAST) begin
                        retry_d = retry_inc;
                        cnt_d   = '0;
                        state_d = (retry_inc == RETRY_LIM) ? S_FAIL : S_RESET;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (!sync2_q) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end else if (cnt_q == ST_LAST) begin
                        state_d = S_LOCKED;
                        retry_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (!sync2_q) begin
                        state_d = S_RESET;
                        cnt_d   = '0;
                        pulse_d = 1'b1;
                        if (lost_q != '1) lost_d = lost_q + 1'b1;
                    end
                end
                S_FAIL: begin
                    if (clr_err) begin
                        state_d = S_RESET;
                        cnt_d   = '0;
                        retry_d = '0;
                    end
                end
                default: state_d = S_DISABLED;
            endcase
        end
        if (clr_err) lost_d = '0;
        rst_d    = (state_d == S_DISABLED) || (state_d == S_RESET) || (state_d == S_FAIL);
        stable_d = (state_d == S_LOCKED);
        fail_d   = (state_d == S_FAIL);
    end

    assign pll_rst    = rst_q;
    assign stable     = stable_q;
    assign lost_pulse = pulse_q;
    assign fail       = fail_q;
    assign lost_cnt   = lost_q;
endmodule

module pll_lock_supervisor #(
    parameter int NUM_CH        = 4,
    parameter int STABLE_CYC    = 1024,
    parameter int TIMEOUT_CYC   = 65536,
    parameter int RST_PULSE_CYC = 16,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_W         = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       pll_lock_in,
    input  logic [NUM_CH-1:0]       enable,
    input  logic                    clr_err,
    output logic [NUM_CH-1:0]       pll_rst_out,
    output logic [NUM_CH-1:0]       lock_stable,
    output logic [NUM_CH-1:0]       lock_lost_pulse,
    output logic [NUM_CH-1:0]       fail,
    output logic [NUM_CH*CNT_W-1:0] lost_cnt,
    output logic                    all_stable,
    output logic                    err_any
);
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pll_lock_ch #(
            .STABLE_CYC   (STABLE_CYC),
            .TIMEOUT_CYC  (TIMEOUT_CYC),
            .RST_PULSE_CYC(RST_PULSE_CYC),
            .MAX_RETRY    (MAX_RETRY),
            .CNT_W        (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .lock_in   (pll_lock_in[g]),
            .enable    (enable[g]),
            .clr_err   (clr_err),
            .pll_rst   (pll_rst_out[g]),
            .stable    (lock_stable[g]),
            .lost_pulse(lock_lost_pulse[g]),
            .fail      (fail[g]),
            .lost_cnt  (lost_cnt[g*CNT_W +: CNT_W])
        );
    end

    assign all_stable = (|enable) && ((lock_stable & enable) == enable);
    assign err_any    = |fail;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with hand-counted cycle expectations
// (NUM_CH=2, STABLE=8, TIMEOUT=32, RST_PULSE=4, MAX_RETRY=2, CNT_W=2).

module tb_pll_lock_supervisor;
    logic       clk, rst_n, clr_err;
    logic [1:0] pll_lock_in, enable;
    logic [1:0] pll_rst_out, lock_stable, lock_lost_pulse, fail;
    logic [3:0] lost_cnt;
    logic       all_stable, err_any;
    int         n_chk = 0, n_fail = 0;

    pll_lock_supervisor #(
        .NUM_CH(2), .STABLE_CYC(8), .TIMEOUT_CYC(32),
        .RST_PULSE_CYC(4), .MAX_RETRY(2), .CNT_W(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_lock_in(pll_lock_in), .enable(enable),
        .clr_err(clr_err), .pll_rst_out(pll_rst_out), .lock_stable(lock_stable),
        .lock_lost_pulse(lock_lost_pulse), .fail(fail), .lost_cnt(lost_cnt),
        .all_stable(all_stable), .err_any(err_any)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rst"},  pll_rst_out, 2'b11);
        chk({tag, "_stab"}, lock_stable, 2'b00);
        chk({tag, "_pls"},  lock_lost_pulse, 2'b00);
        chk({tag, "_fail"}, fail, 2'b00);
        chk({tag, "_lost"}, lost_cnt, 4'h0);
        chk({tag, "_all"},  all_stable, 1'b0);
        chk({tag, "_err"},  err_any, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pll_lock_in = 2'b00;
        clr_err = 1'b0;
        step(3);
        rst_n = 1'b1;
    endtask

    task automatic wait_stable(input int ch, input string tag);
        for (int i = 0; i < 200 && !lock_stable[ch]; i++) step(1);
        chk(tag, lock_stable[ch], 1'b1);
    endtask

    // Lock loss on ch0: pulse lands on the 3rd edge after the drop, then relock.
    task automatic drop0(input logic [1:0] exp_lost, input bit clr_at_loss, input string tag);
        pll_lock_in[0] = 1'b0;
        step(2);
        chk({tag, "_pre"}, lock_lost_pulse[0], 1'b0);
        if (clr_at_loss) clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        chk({tag, "_pulse"}, lock_lost_pulse[0], 1'b1);
        chk({tag, "_cnt"}, lost_cnt[1:0], exp_lost);
        chk({tag, "_unlk"}, lock_stable[0], 1'b0);
        step(1);
        chk({tag, "_post"}, lock_lost_pulse[0], 1'b0);
        pll_lock_in[0] = 1'b1;
        wait_stable(0, {tag, "_relock"});
    endtask

    initial begin
        rst_n = 1'b0;
        enable = 2'b01;
        pll_lock_in = 2'b00;
        clr_err = 1'b0;
        step(3);
        chk_reset_vals("por");

        // Nominal lock
        rst_n = 1'b1;
        step(4);
        chk("nom_rst_hi", pll_rst_out, 2'b11);
        step(1);
        chk("nom_rst_lo", pll_rst_out, 2'b10);
        step(5);
        pll_lock_in[0] = 1'b1;
        step(10);
        chk("nom_early", lock_stable[0], 1'b0);
        chk("nom_all_early", all_stable, 1'b0);
        step(1);
        chk("nom_stable", lock_stable, 2'b01);
        chk("nom_all", all_stable, 1'b1);

        // Losses with saturating counter, then clear coincident with a loss
        drop0(2'd1, 1'b0, "loss1");
        drop0(2'd2, 1'b0, "loss2");
        drop0(2'd3, 1'b0, "loss3");
        drop0(2'd3, 1'b0, "loss4");
        drop0(2'd0, 1'b1, "clrloss");

        // Disable on ch1 wins over its lock loss
        enable = 2'b11;
        pll_lock_in[1] = 1'b1;
        step(1);
        chk("ch1_all_busy", all_stable, 1'b0);
        wait_stable(1, "ch1_lock");
        chk("both_all", all_stable, 1'b1);
        pll_lock_in[1] = 1'b0;
        step(2);
        enable[1] = 1'b0;
        step(1);
        chk("pri_pulse", lock_lost_pulse[1], 1'b0);
        chk("pri_stab", lock_stable[1], 1'b0);
        chk("pri_rst", pll_rst_out[1], 1'b1);
        chk("pri_lost", lost_cnt[3:2], 2'd0);
        chk("pri_all", all_stable, 1'b1);
        step(1);
        chk("pri_pulse2", lock_lost_pulse[1], 1'b0);
        enable = 2'b00;
        step(1);
        chk("none_en_all", all_stable, 1'b0);

        // Settle glitch
        enable = 2'b01;
        do_reset();
        step(5);
        chk("gl_wait", pll_rst_out[0], 1'b0);
        pll_lock_in[0] = 1'b1;
        step(5);
        pll_lock_in[0] = 1'b0;
        step(1);
        pll_lock_in[0] = 1'b1;
        step(5);
        chk("gl_no_lock_a", lock_stable[0], 1'b0);
        step(5);
        chk("gl_no_lock_b", lock_stable[0], 1'b0);
        step(1);
        chk("gl_lock", lock_stable[0], 1'b1);
        chk("gl_lost", lost_cnt, 4'h0);

        // Timeout to FAIL, then clear
        do_reset();
        step(4);
        chk("to_rst1_hi", pll_rst_out[0], 1'b1);
        step(1);
        chk("to_wait1", pll_rst_out[0], 1'b0);
        step(31);
        chk("to_wait1_end", pll_rst_out[0], 1'b0);
        step(1);
        chk("to_rst2_hi", pll_rst_out[0], 1'b1);
        step(3);
        chk("to_rst2_end", pll_rst_out[0], 1'b1);
        chk("to_nofail", fail[0], 1'b0);
        step(1);
        chk("to_wait2", pll_rst_out[0], 1'b0);
        step(31);
        chk("to_wait2_end", fail[0], 1'b0);
        step(1);
        chk("to_fail", fail, 2'b01);
        chk("to_err", err_any, 1'b1);
        chk("to_fail_rst", pll_rst_out[0], 1'b1);
        step(5);
        chk("to_fail_hold", fail[0], 1'b1);
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        chk("clr_fail", fail[0], 1'b0);
        chk("clr_err_any", err_any, 1'b0);
        chk("clr_rst_hi", pll_rst_out[0], 1'b1);
        step(3);
        chk("clr_rst_end", pll_rst_out[0], 1'b1);
        step(1);
        chk("clr_rst_lo", pll_rst_out[0], 1'b0);

        // Async reset mid-SETTLE
        pll_lock_in[0] = 1'b1;
        step(4);
        chk("ar_settle", pll_rst_out[0], 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("ar");
        step(2);
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 The block SHALL have the parameter NUM_CH, default 4 (range 1..8): number of supervised PLL channels.
REQ-002 The block SHALL have the parameter STABLE_CYC, default 1024: consecutive synchronised-lock cycles required before a channel is declared stable.
REQ-003 The block SHALL have the parameter TIMEOUT_CYC, default 65536: maximum cycles to wait for lock after a reset pulse.
REQ-004 The block SHALL have the parameter RST_PULSE_CYC, default 16: width of the PLL reset pulse in cycles.
REQ-005 The block SHALL have the parameter MAX_RETRY, default 3: number of consecutive timeouts that puts a channel into FAIL.
REQ-006 The block SHALL have the parameter CNT_W, default 8: width of each lock-loss counter.
REQ-007 The block SHALL have the port clk, input, 1 bit: single system clock.
REQ-008 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 The block SHALL have the port pll_lock_in, input, NUM_CH bits: raw PLL lock signals, asynchronous to clk.
REQ-010 The block SHALL have the port enable, input, NUM_CH bits: per-channel supervision enable.
REQ-011 The block SHALL have the port clr_err, input, 1 bit: single-cycle clear of FAIL states and all lost counters.
REQ-012 The block SHALL have the port pll_rst_out, output, NUM_CH bits: active-high reset to each PLL.
REQ-013 The block SHALL have the port lock_stable, output, NUM_CH bits: channel is in LOCKED.
REQ-014 The block SHALL have the port lock_lost_pulse, output, NUM_CH bits: one-cycle pulse when a LOCKED channel loses lock.
REQ-015 The block SHALL have the port fail, output, NUM_CH bits: channel is in FAIL.
REQ-016 The block SHALL have the port lost_cnt, output, NUM_CH*CNT_W bits: per-channel lock-loss counters, with channel i at [i*CNT_W +: CNT_W].
REQ-017 The block SHALL have the port all_stable, output, 1 bit: at least one channel is enabled and every enabled channel is LOCKED.
REQ-018 The block SHALL have the port err_any, output, 1 bit: OR of fail.

Function
REQ-019 Each pll_lock_in bit SHALL pass through a 2-flop synchroniser; lock_s denotes the synchroniser output, and all state decisions SHALL use lock_s only.
REQ-020 Each channel SHALL run an independent FSM with the states DISABLED, RESET, WAIT_LOCK, SETTLE, LOCKED and FAIL.
REQ-021 In DISABLED: pll_rst_out=1; enable=1 -> RESET, retry counter cleared to 0.
REQ-022 In RESET: pll_rst_out=1 for exactly RST_PULSE_CYC cycles, then -> WAIT_LOCK with the timeout counter cleared.
REQ-023 In WAIT_LOCK: pll_rst_out=0; lock_s=1 -> SETTLE.
REQ-024 In WAIT_LOCK: when the counter reaches TIMEOUT_CYC with lock_s=0, retry increments; if the new retry equals MAX_RETRY -> FAIL, else -> RESET.
REQ-025 In SETTLE: lock_s=0 -> WAIT_LOCK with the timeout counter restarted; STABLE_CYC consecutive cycles with lock_s=1 -> LOCKED, retry cleared.
REQ-026 In LOCKED: lock_stable=1; lock_s=0 -> RESET in the next cycle, lock_lost_pulse=1 for that single cycle, lost_cnt increments.
REQ-027 In FAIL: fail=1 and pll_rst_out=1; clr_err=1 -> RESET with retry cleared to 0.
REQ-028 enable=0 SHALL force DISABLED on the next clock from any state, with priority over every other transition.
REQ-029 lost_cnt SHALL saturate at 2^CNT_W-1 and SHALL never wrap.
REQ-030 clr_err SHALL clear every lost_cnt to 0; when clr_err coincides with a lock loss, the counter SHALL read 0 afterwards (clear wins), while the pulse and transition still occur.
REQ-031 Latency from a pll_lock_in rise while in WAIT_LOCK to the SETTLE state SHALL be 3 clk edges (2 synchroniser + 1 FSM).
REQ-032 Latency from the start of SETTLE to lock_stable=1 SHALL be STABLE_CYC cycles.
REQ-033 All outputs SHALL be registered, except all_stable and err_any, which SHALL be combinational from registered state.
REQ-034 Disabled channels SHALL be excluded from all_stable.
REQ-035 all_stable SHALL be 0 when enable is all zeros.
REQ-036 Internal counters SHALL be sized to hold their parameter values; parameters equal to 1 SHALL be legal.

Reset
REQ-037 While rst_n=0, every FSM SHALL be in DISABLED and the synchroniser flops and all counters SHALL be 0.
REQ-038 While rst_n=0: pll_rst_out all ones; lock_stable, lock_lost_pulse, fail, lost_cnt, all_stable and err_any all zero.
REQ-039 Reset asserted mid-operation SHALL abandon the state immediately, without emitting lock_lost_pulse.
REQ-040 After rst_n deasserts, a channel with enable=1 SHALL enter RESET on the first clock.

Verification
Bench parameters for all scenarios: NUM_CH=2, STABLE_CYC=8, TIMEOUT_CYC=32, RST_PULSE_CYC=4, MAX_RETRY=2, CNT_W=2.
REQ-041 Nominal lock: enable=2'b01, lock_in[0] rises 10 cycles after reset -> pll_rst_out[0] high 4 cycles, then lock_stable[0]=1 and all_stable=1 exactly 8+3 cycles after the rise.
REQ-042 Timeout to fail: lock_in held 0 -> two reset pulses of 4 cycles each, 32-cycle waits, then fail[0]=1 and err_any=1; clr_err pulse -> fail=0, new 4-cycle reset pulse.
REQ-043 Settle glitch: lock_in high 5 cycles, low 1, high again -> no lock_stable until 8 continuous cycles; lost_cnt unchanged.
REQ-044 Loss and saturation: drop lock in LOCKED 4 times -> 4 single-cycle lock_lost_pulses, lost_cnt[0] reads 1, 2, 3, 3.
REQ-045 Priority: enable[1]=0 in the same cycle as a lock loss on channel 1 -> DISABLED, no pulse; clr_err coincident with a loss on channel 0 -> lost_cnt[0]=0, pulse present.
REQ-046 Async reset: rst_n low mid-SETTLE -> all outputs at reset values within the same cycle; all_stable=0.
